// File: rtl/reg_file_2r1w_if.sv
// Register-file access bundle: one write port, two read ports,
// and the always-visible config buses REG0..REG3.
interface reg_file_2r1w_if #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDRESS_BITS = 4
);
  logic                    W_REG_EN;
  logic [ADDRESS_BITS-1:0] W_REG_ADDRESS;
  logic [DATA_WIDTH-1:0]   W_REG_DATA;
  logic                    WR_ERR;

  logic                    RA_REG_EN;
  logic [ADDRESS_BITS-1:0] RA_REG_ADDRESS;
  logic [DATA_WIDTH-1:0]   RA_REG_DATA;
  logic                    RA_DATA_VALID;
  logic                    RA_ERR;

  logic                    RB_REG_EN;
  logic [ADDRESS_BITS-1:0] RB_REG_ADDRESS;
  logic [DATA_WIDTH-1:0]   RB_REG_DATA;
  logic                    RB_DATA_VALID;
  logic                    RB_ERR;

  logic [DATA_WIDTH-1:0]   REG0;
  logic [DATA_WIDTH-1:0]   REG1;
  logic [DATA_WIDTH-1:0]   REG2;
  logic [DATA_WIDTH-1:0]   REG3;

  modport master (
    output W_REG_EN, W_REG_ADDRESS, W_REG_DATA,
    input  WR_ERR,
    output RA_REG_EN, RA_REG_ADDRESS,
    input  RA_REG_DATA, RA_DATA_VALID, RA_ERR,
    output RB_REG_EN, RB_REG_ADDRESS,
    input  RB_REG_DATA, RB_DATA_VALID, RB_ERR,
    input  REG0, REG1, REG2, REG3
  );

  modport slave (
    input  W_REG_EN, W_REG_ADDRESS, W_REG_DATA,
    output WR_ERR,
    input  RA_REG_EN, RA_REG_ADDRESS,
    output RA_REG_DATA, RA_DATA_VALID, RA_ERR,
    input  RB_REG_EN, RB_REG_ADDRESS,
    output RB_REG_DATA, RB_DATA_VALID, RB_ERR,
    output REG0, REG1, REG2, REG3
  );
endinterface

// File: rtl/reg_file_2r1w.sv
// 2-read/1-write register file: registered reads with write-first
// bypass, per-entry reset image, per-entry write protection.
module reg_file_2r1w #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDRESS_BITS = 4,
  parameter int DEPTH        = 16,
  parameter logic [DEPTH*DATA_WIDTH-1:0] RST_VECTOR =
    128'h0000_0000_0000_0000_0000_0000_2081_0000,
  parameter logic [DEPTH-1:0] WR_PROT_MASK = 16'h0000
) (
  input logic             CLK,
  input logic             RST,
  reg_file_2r1w_if.slave  io_rf
);

  localparam int AB = ADDRESS_BITS;
  localparam int DW = DATA_WIDTH;
  localparam logic [AB:0] L_DEPTH = (AB+1)'(DEPTH);

  logic [DW-1:0] w_ent [DEPTH];

  logic          w_wr_inr;
  logic          w_wr_prot;
  logic          w_wr_ok;
  logic          w_ra_oor;
  logic          w_rb_oor;
  logic [DW-1:0] w_ra_mux;
  logic [DW-1:0] w_rb_mux;

  logic [DW-1:0] r_ra_data;
  logic          r_ra_vld;
  logic          r_ra_err;
  logic [DW-1:0] r_rb_data;
  logic          r_rb_vld;
  logic          r_rb_err;
  logic          r_wr_err;

  assign w_wr_inr = {1'b0, io_rf.W_REG_ADDRESS} < L_DEPTH;
  assign w_ra_oor = !({1'b0, io_rf.RA_REG_ADDRESS} < L_DEPTH);
  assign w_rb_oor = !({1'b0, io_rf.RB_REG_ADDRESS} < L_DEPTH);

  always_comb begin
    w_wr_prot = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (io_rf.W_REG_ADDRESS == AB'(i))
        w_wr_prot = WR_PROT_MASK[i];
    end
  end

  assign w_wr_ok = io_rf.W_REG_EN && w_wr_inr && !w_wr_prot;

  // Protected entries are constants; only writable ones get flops.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
    localparam logic [DW-1:0] L_RST =
      RST_VECTOR[gi*DW +: DW];
    if (WR_PROT_MASK[gi]) begin : g_ro
      assign w_ent[gi] = L_RST;
    end else begin : g_rw
      logic [DW-1:0] r_val;
      logic          w_hit;
      assign w_hit = w_wr_ok &&
        (io_rf.W_REG_ADDRESS == AB'(gi));
      always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
          r_val <= L_RST;
        else if (w_hit)
          r_val <= io_rf.W_REG_DATA;
      end
      assign w_ent[gi] = r_val;
    end
  end

  // Out-of-range addresses match no entry and fall through as zero.
  always_comb begin
    w_ra_mux = '0;
    w_rb_mux = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (io_rf.RA_REG_ADDRESS == AB'(i))
        w_ra_mux = w_ent[i];
      if (io_rf.RB_REG_ADDRESS == AB'(i))
        w_rb_mux = w_ent[i];
    end
    if (w_wr_ok &&
        io_rf.W_REG_ADDRESS == io_rf.RA_REG_ADDRESS)
      w_ra_mux = io_rf.W_REG_DATA;
    if (w_wr_ok &&
        io_rf.W_REG_ADDRESS == io_rf.RB_REG_ADDRESS)
      w_rb_mux = io_rf.W_REG_DATA;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_ra_data <= '0;
      r_ra_vld  <= 1'b0;
      r_ra_err  <= 1'b0;
      r_rb_data <= '0;
      r_rb_vld  <= 1'b0;
      r_rb_err  <= 1'b0;
      r_wr_err  <= 1'b0;
    end else begin
      r_wr_err <= io_rf.W_REG_EN && !w_wr_ok;
      r_ra_vld <= io_rf.RA_REG_EN;
      r_ra_err <= io_rf.RA_REG_EN && w_ra_oor;
      r_rb_vld <= io_rf.RB_REG_EN;
      r_rb_err <= io_rf.RB_REG_EN && w_rb_oor;
      if (io_rf.RA_REG_EN)
        r_ra_data <= w_ra_mux;
      if (io_rf.RB_REG_EN)
        r_rb_data <= w_rb_mux;
    end
  end

  assign io_rf.WR_ERR        = r_wr_err;
  assign io_rf.RA_REG_DATA   = r_ra_data;
  assign io_rf.RA_DATA_VALID = r_ra_vld;
  assign io_rf.RA_ERR        = r_ra_err;
  assign io_rf.RB_REG_DATA   = r_rb_data;
  assign io_rf.RB_DATA_VALID = r_rb_vld;
  assign io_rf.RB_ERR        = r_rb_err;

  assign io_rf.REG0 = w_ent[0];
  assign io_rf.REG1 = w_ent[1];
  assign io_rf.REG2 = w_ent[2];
  assign io_rf.REG3 = w_ent[3];

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Bench for reg_file_2r1w: DEPTH=12 with entry 2 protected, so range
// checks and protection are exercised on one instance.
module tb_reg_file_2r1w;

  localparam int D = 12;
  localparam logic [D-1:0] PROT = 12'h004;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  reg_file_2r1w_if #(.DATA_WIDTH(8), .ADDRESS_BITS(4)) rf();

  reg_file_2r1w #(
    .DATA_WIDTH  (8),
    .ADDRESS_BITS(4),
    .DEPTH       (D),
    .RST_VECTOR  (96'h0000_0000_0000_0000_2081_0000),
    .WR_PROT_MASK(PROT)
  ) dut (
    .CLK  (clk),
    .RST  (rst_n),
    .io_rf(rf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain array plus expected output registers.
  logic [7:0] m_mem [D];
  logic [7:0] m_ra, m_rb;
  logic       m_rav, m_rbv, m_rae, m_rbe, m_we;

  function automatic logic [7:0] rst_val(input int i);
    if (i == 2) return 8'h81;
    if (i == 3) return 8'h20;
    return 8'h00;
  endfunction

  function automatic bit acc(input logic en, input int a);
    return en && a < D && !PROT[a];
  endfunction

  function automatic logic [7:0] rd(input int a, input bit wok,
      input int wa, input logic [7:0] wd, input logic [7:0] st);
    if (a >= D) return 8'h00;
    if (wok && wa == a) return wd;
    return st;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < D; i++) m_mem[i] <= rst_val(i);
      {m_ra, m_rb} <= '0;
      {m_rav, m_rbv, m_rae, m_rbe, m_we} <= '0;
    end else begin
      automatic int  wa = int'(rf.W_REG_ADDRESS);
      automatic int  aa = int'(rf.RA_REG_ADDRESS);
      automatic int  ba = int'(rf.RB_REG_ADDRESS);
      automatic bit  ok = acc(rf.W_REG_EN, wa);
      m_we <= rf.W_REG_EN && !ok;
      if (ok) m_mem[wa] <= rf.W_REG_DATA;
      m_rav <= rf.RA_REG_EN;
      m_rae <= rf.RA_REG_EN && aa >= D;
      m_rbv <= rf.RB_REG_EN;
      m_rbe <= rf.RB_REG_EN && ba >= D;
      if (rf.RA_REG_EN)
        m_ra <= rd(aa, ok, wa, rf.W_REG_DATA,
                   aa < D ? m_mem[aa % D] : 8'h00);
      if (rf.RB_REG_EN)
        m_rb <= rd(ba, ok, wa, rf.W_REG_DATA,
                   ba < D ? m_mem[ba % D] : 8'h00);
    end
  end

  // Whole-output comparison every cycle, away from the rising edge.
  always @(negedge clk) begin
    automatic logic [52:0] act = {rf.RA_REG_DATA, rf.RB_REG_DATA,
      rf.RA_DATA_VALID, rf.RB_DATA_VALID, rf.RA_ERR, rf.RB_ERR,
      rf.WR_ERR, rf.REG0, rf.REG1, rf.REG2, rf.REG3};
    automatic logic [52:0] exp = {m_ra, m_rb, m_rav, m_rbv,
      m_rae, m_rbe, m_we, m_mem[0], m_mem[1], m_mem[2], m_mem[3]};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL model t=%0t got=%h want=%h", $time, act, exp);
    end
  end

  task automatic chk(input string nm, input logic [7:0] a,
                     input logic [7:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", nm, a, e);
    end
  endtask

  task automatic drv(input logic we, input logic [3:0] wa,
      input logic [7:0] wd, input logic ae, input logic [3:0] aa,
      input logic be, input logic [3:0] ba);
    rf.W_REG_EN = we; rf.W_REG_ADDRESS = wa; rf.W_REG_DATA = wd;
    rf.RA_REG_EN = ae; rf.RA_REG_ADDRESS = aa;
    rf.RB_REG_EN = be; rf.RB_REG_ADDRESS = ba;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ra_data", rf.RA_REG_DATA, 8'h00);
    chk("rst_ra_vld", {7'b0, rf.RA_DATA_VALID}, 8'h00);
    chk("rst_wr_err", {7'b0, rf.WR_ERR}, 8'h00);
    chk("rst_reg2", rf.REG2, 8'h81);
    chk("rst_reg3", rf.REG3, 8'h20);
    #10 rst_n = 1'b1;

    drv(0, 0, 0, 1, 4'd2, 1, 4'd3);
    tick;
    chk("rd_a2", rf.RA_REG_DATA, 8'h81);
    chk("rd_b3", rf.RB_REG_DATA, 8'h20);
    chk("rd_vld", {6'b0, rf.RA_DATA_VALID, rf.RB_DATA_VALID}, 8'h03);
    drv(0, 0, 0, 0, 0, 0, 0);
    tick;
    chk("hold_a", rf.RA_REG_DATA, 8'h81);
    chk("idle_vld", {6'b0, rf.RA_DATA_VALID, rf.RB_DATA_VALID}, 8'h00);

    drv(1, 4'd7, 8'h0F, 0, 0, 0, 0);
    tick;
    chk("wr7_err", {7'b0, rf.WR_ERR}, 8'h00);
    drv(0, 0, 0, 1, 4'd7, 0, 0);
    tick;
    chk("rd_a7", rf.RA_REG_DATA, 8'h0F);
    chk("rd_a7_vld", {7'b0, rf.RA_DATA_VALID}, 8'h01);

    drv(1, 4'd1, 8'hFF, 1, 4'd1, 1, 4'd1);
    tick;
    chk("byp_a1", rf.RA_REG_DATA, 8'hFF);
    chk("byp_b1", rf.RB_REG_DATA, 8'hFF);
    chk("reg1", rf.REG1, 8'hFF);

    drv(1, 4'd2, 8'h55, 0, 0, 0, 0);
    tick;
    chk("prot_err", {7'b0, rf.WR_ERR}, 8'h01);
    drv(1, 4'd2, 8'h66, 1, 4'd2, 0, 0);
    tick;
    chk("prot_nobyp", rf.RA_REG_DATA, 8'h81);
    chk("prot_err2", {7'b0, rf.WR_ERR}, 8'h01);
    drv(0, 0, 0, 1, 4'd2, 0, 0);
    tick;
    chk("prot_rd", rf.RA_REG_DATA, 8'h81);
    chk("err_clr", {7'b0, rf.WR_ERR}, 8'h00);

    drv(1, 4'd12, 8'hAA, 1, 4'd13, 1, 4'd11);
    tick;
    chk("oor_data", rf.RA_REG_DATA, 8'h00);
    chk("oor_flags", {5'b0, rf.RA_DATA_VALID, rf.RA_ERR, rf.WR_ERR},
        8'h07);
    chk("inr_b11", {7'b0, rf.RB_ERR}, 8'h00);
    drv(1, 4'd11, 8'h3C, 0, 0, 1, 4'd11);
    tick;
    chk("edge_b11", rf.RB_REG_DATA, 8'h3C);
    drv(1, 4'd15, 8'h99, 1, 4'd7, 0, 0);
    tick;
    chk("b2b_a7", rf.RA_REG_DATA, 8'h0F);
    chk("wr15_err", {7'b0, rf.WR_ERR}, 8'h01);
    drv(0, 0, 0, 1, 4'd1, 0, 0);
    tick;
    chk("b2b_a1", rf.RA_REG_DATA, 8'hFF);
    chk("b2b_vld", {7'b0, rf.RA_DATA_VALID}, 8'h01);

    drv(1, 4'd5, 8'h77, 1, 4'd5, 0, 0);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_reg1", rf.REG1, 8'h00);
    chk("arst_vld", {7'b0, rf.RA_DATA_VALID}, 8'h00);
    tick;
    chk("arst_hold_vld", {7'b0, rf.RA_DATA_VALID}, 8'h00);
    drv(0, 0, 0, 0, 0, 0, 0);
    #3 rst_n = 1'b1;
    tick;
    chk("post_vld", {7'b0, rf.RA_DATA_VALID}, 8'h00);
    drv(0, 0, 0, 1, 4'd7, 1, 4'd5);
    tick;
    chk("post_a7", rf.RA_REG_DATA, 8'h00);
    chk("post_b5", rf.RB_REG_DATA, 8'h00);
    chk("post_reg2", rf.REG2, 8'h81);
    drv(0, 0, 0, 0, 0, 0, 0);
    tick;
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
- Parametrised successor to the single-port register file: one write port, two independent read ports.
- Registered reads with per-port valid; write-first bypass on address collision.
- Per-entry reset values and per-entry write protection; error flags for illegal accesses.
- Sits between the system controller and the config consumers (UART/ALU/clock divider); REG0..REG3 stay exported as always-visible config buses.

Parameters:
- DATA_WIDTH, 8, width of each entry.
- ADDRESS_BITS, 4, width of all address ports.
- DEPTH, 16, number of implemented entries; must satisfy 4 <= DEPTH <= 2**ADDRESS_BITS.
- RST_VECTOR, 128'h0000_0000_0000_0000_0000_0000_2081_0000, flat reset image, width DEPTH*DATA_WIDTH. Entry i = [i*DATA_WIDTH +: DATA_WIDTH]. Default gives entry2=8'h81, entry3=8'h20, all others 0.
- WR_PROT_MASK, 16'h0000, width DEPTH. Bit i=1 makes entry i read-only; it holds its reset value permanently.

Ports:
- CLK  in  1  clock, all state on rising edge.
- RST  in  1  asynchronous, active-low reset.
- W_REG_EN  in  1  write request.
- W_REG_ADDRESS  in  ADDRESS_BITS  write address.
- W_REG_DATA  in  DATA_WIDTH  write data.
- WR_ERR  out  1  one-cycle pulse: write rejected (protected or out of range).
- RA_REG_EN  in  1  read request, port A.
- RA_REG_ADDRESS  in  ADDRESS_BITS  read address, port A.
- RA_REG_DATA  out  DATA_WIDTH  read data, port A.
- RA_DATA_VALID  out  1  one-cycle pulse qualifying RA_REG_DATA.
- RA_ERR  out  1  one-cycle pulse: port A read out of range.
- RB_REG_EN, RB_REG_ADDRESS, RB_REG_DATA, RB_DATA_VALID, RB_ERR: same as port A, for port B.
- REG0, REG1, REG2, REG3  out  DATA_WIDTH each  live contents of entries 0..3, no latency.

Behaviour:
- Reset (RST=0, async):
  - Every entry loads its RST_VECTOR slice.
  - RA/RB_REG_DATA=0; RA/RB_DATA_VALID=0; RA/RB_ERR=0; WR_ERR=0.
  - REG0..3 reflect the reset image immediately, without waiting for a clock.
- Reset asserted mid-operation: any in-flight read is dropped, so no VALID pulse follows; any same-edge write is lost.
- Write:
  - When W_REG_EN=1, address < DEPTH and WR_PROT_MASK[address]=0, the entry updates on the edge.
  - Otherwise the entry is unchanged and WR_ERR=1 for exactly the next cycle.
  - WR_ERR=0 whenever W_REG_EN=0.
- Read (each port independent, latency 1):
  - A request sampled on edge N gives data/VALID stable from edge N until edge N+1.
  - VALID=1 for exactly one cycle per request cycle.
  - Back-to-back requests give back-to-back VALID pulses, no bubble.
  - Without a request, DATA holds its last value and VALID=0.
- Read address >= DEPTH: DATA=0, VALID=1, ERR=1 for that cycle.
- Collision bypass: a read and an accepted write to the same address on the same edge return the new write data (write-first). A rejected write does not bypass; the read returns the stored value.
- Ports A and B may read the same or different addresses in the same cycle with no interaction.
- REG0..3 update on the same edge as the write that changes them.
- Address wrap: none. Addresses are never truncated modulo DEPTH.
- Purely sequential register array, no FSM; all outputs are registered except REG0..3.

Test Plan:
- Release reset; read A@2, B@3 in the same cycle -> next cycle RA_REG_DATA=8'h81, RB_REG_DATA=8'h20, both VALID=1; REG2=8'h81, REG3=8'h20.
- Write 8'h0F @7, then read A@7 -> 8'h0F with VALID, 1 cycle after the read request; WR_ERR stays 0.
- Same edge: write 8'hFF @1, read A@1 and B@1 -> both return 8'hFF; REG1=8'hFF after that edge.
- WR_PROT_MASK=16'h0004; write 8'h55 @2 -> WR_ERR pulses 1 cycle; read @2 -> 8'h81.
- DEPTH=12, ADDRESS_BITS=4: read A@13 -> DATA=0, VALID=1, RA_ERR=1; write @12 -> WR_ERR=1; no entry changes.
- Issue read A@5, drop RST low before the next edge -> no RA_DATA_VALID pulse; all entries back to RST_VECTOR, including a previously written @7 returning to 0.
